// File: rtl/byte_mem_adapter.sv
// Bridges a 16-bit CPU memory port onto an 8-bit physical memory, one byte per
// pmem handshake. A byte that never sees pmem_ack is abandoned after TIMEOUT
// cycles. Its read data then becomes 8'hFF and the sticky err flag sets.
module byte_mem_adapter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        pmem_req,
  output logic        pmem_we,
  output logic [15:0] pmem_address,
  output logic [7:0]  pmem_wdata,
  input  logic [7:0]  pmem_rdata,
  input  logic        pmem_ack,
  output logic        err
);
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LO_REQ, HI_REQ, RESP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt, cnt_nxt;
  logic                op_write;
  logic                be_hi_q;
  logic [ADDR_W-1:1]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [BYTE_W-1:0]   lo_q;

  logic                accept;
  logic                byte_done;
  logic                timed_out;
  logic [BYTE_W-1:0]   byte_val;
  logic                op_nxt;
  logic [ADDR_W-1:1]   addr_base;
  logic [WORD_W-1:0]   wdata_base;
  logic                req_nxt;
  logic                hi_nxt;

  // Byte address bit 0 is ignored: accesses are always word-aligned pairs.
  logic unused_addr_lsb;
  assign unused_addr_lsb = mem_address[0];

  // State and per-byte wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  // Next-state decode, byte completion (ack or timeout), and next output values.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    accept    = 1'b0;
    byte_done = 1'b0;
    timed_out = 1'b0;
    byte_val  = pmem_rdata;
    case (state)
      IDLE: begin
        if (mem_read) begin
          accept    = 1'b1;
          state_nxt = LO_REQ;
        end else if (mem_write) begin
          accept = 1'b1;
          if (mem_byte_enable[0])      state_nxt = LO_REQ;
          else if (mem_byte_enable[1]) state_nxt = HI_REQ;
          else                         state_nxt = RESP;
        end
      end
      LO_REQ, HI_REQ: begin
        if (pmem_ack) begin
          byte_done = 1'b1;
        end else if (wait_cnt == CNT_LAST) begin
          byte_done = 1'b1;
          timed_out = 1'b1;
          byte_val  = 8'hFF;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
        if (byte_done) begin
          if (state == LO_REQ && (!op_write || be_hi_q)) state_nxt = HI_REQ;
          else                                           state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    op_nxt     = accept ? !mem_read : op_write;
    addr_base  = accept ? mem_address[ADDR_W-1:1] : addr_q;
    wdata_base = accept ? mem_wdata : wdata_q;
    req_nxt    = (state_nxt == LO_REQ) || (state_nxt == HI_REQ);
    hi_nxt     = (state_nxt == HI_REQ);
  end

  // Request capture, read-byte assembly, sticky error and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_write     <= 1'b0;
      be_hi_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      mem_rdata    <= '0;
      err          <= 1'b0;
      mem_resp     <= 1'b0;
      pmem_req     <= 1'b0;
      pmem_we      <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      if (accept) begin
        op_write <= !mem_read;
        be_hi_q  <= mem_byte_enable[1];
        addr_q   <= mem_address[ADDR_W-1:1];
        wdata_q  <= mem_wdata;
      end
      if (state == LO_REQ && byte_done) lo_q <= byte_val;
      if (state == HI_REQ && byte_done && !op_write) mem_rdata <= {byte_val, lo_q};
      if (timed_out) err <= 1'b1;
      mem_resp <= (state_nxt == RESP);
      pmem_req <= req_nxt;
      pmem_we  <= req_nxt & op_nxt;
      if (req_nxt) begin
        pmem_address <= {addr_base, hi_nxt};
        pmem_wdata   <= hi_nxt ? wdata_base[WORD_W-1:BYTE_W] : wdata_base[BYTE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_byte_mem_adapter.sv
// Self-checking bench for byte_mem_adapter: a transaction-level model predicts
// the pmem byte accesses, response latency, read word and sticky error.
module tb_byte_mem_adapter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        pmem_req, pmem_we;
  logic [15:0] pmem_address;
  logic [7:0]  pmem_wdata, pmem_rdata;
  logic        pmem_ack;
  logic        err;

  byte_mem_adapter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_req(pmem_req), .pmem_we(pmem_we), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_ack(pmem_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  // Physical byte memory and model state.
  logic [7:0]  mem [0:65535];
  logic [24:0] exp_acc [$];   // {we, address, wdata}
  logic        exp_err;
  logic [15:0] exp_rdata;
  bit          active;
  int          wait_j;
  logic [24:0] snap;
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Called once per negedge: checks the pmem side and plays the memory.
  task automatic respond(input int dly, input bit wh_hi);
    logic [24:0] e;
    logic [24:0] cur;
    pmem_ack   = 1'b0;
    pmem_rdata = 8'($urandom);
    cur = {pmem_we, pmem_address, pmem_wdata};
    if (pmem_req) begin
      if (!active) begin
        active = 1'b1;
        wait_j = 0;
        snap   = cur;
        if (exp_acc.size() == 0) begin
          chk("pmem_req_unexpected", 32'(pmem_req), 32'd0);
        end else begin
          e = exp_acc.pop_front();
          chk("pmem_address", 32'(pmem_address), 32'(e[23:8]));
          chk("pmem_we", 32'(pmem_we), 32'(e[24]));
          if (e[24]) chk("pmem_wdata", 32'(pmem_wdata), 32'(e[7:0]));
        end
      end else begin
        chk("pmem_stable", 32'(cur), 32'(snap));
      end
      if (wait_j >= dly && !(wh_hi && pmem_address[0])) begin
        pmem_ack = 1'b1;
        if (pmem_we) mem[pmem_address] = pmem_wdata;
        else         pmem_rdata = mem[pmem_address];
        active = 1'b0;
      end else begin
        wait_j++;
        if (wait_j == TO) active = 1'b0;
      end
    end else begin
      active   = 1'b0;
      pmem_ack = 1'($urandom_range(0, 1));
    end
  endtask

  // One CPU transaction; must be entered at a negedge with the DUT idle.
  task automatic run_txn(input bit rd, input logic [1:0] be, input logic [15:0] addr,
                         input logic [15:0] wd, input int dly, input bit wh_hi,
                         output int lat);
    int L, c_lo, c_hi, resp_n;
    bit to_lo, to_hi;
    logic [15:0] a0, a1;
    logic [7:0] elo, ehi;
    a0 = {addr[15:1], 1'b0};
    a1 = {addr[15:1], 1'b1};
    to_lo = (dly >= TO);
    to_hi = (dly >= TO) || (rd && wh_hi);
    c_lo  = to_lo ? TO : dly + 1;
    c_hi  = to_hi ? TO : dly + 1;
    exp_acc.delete();
    L = 1;
    if (rd) begin
      exp_acc.push_back({1'b0, a0, 8'h00});
      exp_acc.push_back({1'b0, a1, 8'h00});
      L += c_lo + c_hi;
      elo = to_lo ? 8'hFF : mem[a0];
      ehi = to_hi ? 8'hFF : mem[a1];
      exp_rdata = {ehi, elo};
      if (to_lo || to_hi) exp_err = 1'b1;
    end else begin
      if (be[0]) begin
        exp_acc.push_back({1'b1, a0, wd[7:0]});
        L += c_lo;
        if (to_lo) exp_err = 1'b1;
      end
      if (be[1]) begin
        exp_acc.push_back({1'b1, a1, wd[15:8]});
        L += c_lo;
        if (to_lo) exp_err = 1'b1;
      end
    end
    mem_read        = rd;
    mem_write       = rd ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wd;
    pmem_ack        = 1'($urandom_range(0, 1));
    pmem_rdata      = 8'($urandom);
    @(posedge clk);
    resp_n = 0;
    lat    = 0;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mem_address     = 16'($urandom);
        mem_wdata       = 16'($urandom);
        mem_byte_enable = 2'($urandom);
      end
      respond(dly, rd && wh_hi);
      chk("mem_resp", 32'(mem_resp), 32'(k == L));
      if (mem_resp) begin
        resp_n++;
        lat       = k;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk("resp_count", 32'(resp_n), 32'd1);
    chk("acc_left", 32'(exp_acc.size()), 32'd0);
    chk("mem_rdata", 32'(mem_rdata), 32'(exp_rdata));
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_resp"}, 32'(mem_resp), 32'd0);
    chk({tag, "_pmem_req"}, 32'(pmem_req), 32'd0);
    chk({tag, "_pmem_we"}, 32'(pmem_we), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mem_rdata"}, 32'(mem_rdata), 32'd0);
    chk({tag, "_pmem_address"}, 32'(pmem_address), 32'd0);
    chk({tag, "_pmem_wdata"}, 32'(pmem_wdata), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int lat;
    bit hit;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
    mem_address = '0; mem_wdata = '0; pmem_ack = 1'b0; pmem_rdata = '0;
    exp_err = 1'b0; exp_rdata = '0; active = 1'b0; wait_j = 0; snap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Two-byte read, immediate ack.
    mem[16'h1234] = 8'hCD;
    mem[16'h1235] = 8'hAB;
    run_txn(1'b1, 2'b00, 16'h1235, 16'h0000, 0, 1'b0, lat);
    chk("rd_word_literal", 32'(mem_rdata), 32'h0000ABCD);
    chk("rd_latency_literal", 32'(lat), 32'd3);

    // High-byte-only write.
    mem[16'h0040] = 8'h11;
    mem[16'h0041] = 8'h22;
    run_txn(1'b0, 2'b10, 16'h0040, 16'hBEEF, 0, 1'b0, lat);
    chk("wr_hi_byte_literal", 32'(mem[16'h0041]), 32'h000000BE);
    chk("wr_lo_untouched_literal", 32'(mem[16'h0040]), 32'h00000011);
    chk("wr1_latency_literal", 32'(lat), 32'd2);
    chk("wr_keeps_rdata_literal", 32'(mem_rdata), 32'h0000ABCD);

    // Empty byte enable: no pmem traffic.
    run_txn(1'b0, 2'b00, 16'h1000, 16'h1234, 0, 1'b0, lat);
    chk("wr0_latency_literal", 32'(lat), 32'd1);

    // Slow memory: three wait cycles per byte.
    run_txn(1'b1, 2'b00, 16'h3000, 16'h0000, 3, 1'b0, lat);
    chk("slow_rd_latency_literal", 32'(lat), 32'd9);
    chk("slow_no_err_literal", 32'(err), 32'd0);

    run_txn(1'b0, 2'b11, 16'h2223, 16'h5A6B, 1, 1'b0, lat);
    chk("wr2_latency_literal", 32'(lat), 32'd5);

    // High byte never acknowledged.
    run_txn(1'b1, 2'b00, 16'h5000, 16'h0000, 0, 1'b1, lat);
    chk("timeout_hi_literal", 32'(mem_rdata[15:8]), 32'h000000FF);
    chk("timeout_latency_literal", 32'(lat), 32'd6);
    chk("timeout_err_literal", 32'(err), 32'd1);

    // Randomized mix; delays at or beyond TIMEOUT exercise abandonment.
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 16'($urandom),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 1)) : int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0), lat);
    end
    chk("err_sticky_literal", 32'(err), 32'd1);

    // Reset while waiting on the high byte.
    exp_acc.delete();
    exp_acc.push_back({1'b0, 16'h2000, 8'h00});
    exp_acc.push_back({1'b0, 16'h2001, 8'h00});
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h2001; pmem_ack = 1'b0;
    @(posedge clk);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      respond(3, 1'b0);
      if (pmem_req && pmem_address[0]) hit = 1'b1;
    end
    chk("reached_hi_req", 32'(hit), 32'd1);
    rst_n = 1'b0; mem_read = 1'b0; pmem_ack = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    active = 1'b0; exp_err = 1'b0; exp_rdata = '0;
    @(negedge clk);
    chk("after_reset_no_resp", 32'(mem_resp), 32'd0);
    run_txn(1'b1, 2'b00, 16'h2001, 16'h0000, 0, 1'b0, lat);
    chk("post_reset_latency_literal", 32'(lat), 32'd3);
    chk("post_reset_err_literal", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_mem_adapter.md
BYTE_MEM_ADAPTER -- requirements
Module: byte_mem_adapter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL be the number of cycles a byte request waits for pmem_ack before it is abandoned.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 mem_read  input  1  SHALL be the CPU read request, held until mem_resp.
REQ-005 mem_write  input  1  SHALL be the CPU write request, held until mem_resp.
REQ-006 mem_byte_enable  input  2  SHALL be the CPU write byte mask: bit0 = low byte, bit1 = high byte.
REQ-007 mem_address  input  16  SHALL be the CPU byte address; bit 0 is ignored.
REQ-008 mem_wdata  input  16  SHALL be the CPU write data.
REQ-009 mem_resp  output  1  SHALL be a one-cycle completion pulse to the CPU.
REQ-010 mem_rdata  output  16  SHALL be the assembled read word {high byte, low byte}.
REQ-011 pmem_req  output  1  SHALL be the physical byte-memory request.
REQ-012 pmem_we  output  1  SHALL be the physical write strobe, qualified by pmem_req.
REQ-013 pmem_address  output  16  SHALL be the physical byte address.
REQ-014 pmem_wdata  output  8  SHALL be the physical write byte.
REQ-015 pmem_rdata  input  8  SHALL be the physical read byte, valid with pmem_ack.
REQ-016 pmem_ack  input  1  SHALL be the physical completion, one cycle per byte.
REQ-017 err  output  1  SHALL be the sticky timeout flag.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LO_REQ, HI_REQ, RESP.
REQ-019 In IDLE, when mem_read or mem_write is high, the block SHALL register the address, wdata, byte enable and operation; read takes priority when both are high.
REQ-020 Reads SHALL always transfer both bytes: LO_REQ at {addr[15:1],0}, then HI_REQ at {addr[15:1],1}.
REQ-021 Writes SHALL visit LO_REQ only if be[0]=1 and HI_REQ only if be[1]=1; be=00 SHALL go IDLE->RESP with no pmem traffic.
REQ-022 pmem_req SHALL be high exactly in LO_REQ and HI_REQ; pmem_we = registered op is write; pmem_wdata = wdata[7:0] in LO_REQ and wdata[15:8] in HI_REQ.
REQ-023 pmem_address, pmem_we and pmem_wdata SHALL remain stable while a given state holds pmem_req high.
REQ-024 pmem_ack in LO_REQ SHALL capture pmem_rdata into the low byte and advance (HI_REQ if required, else RESP); pmem_ack in HI_REQ SHALL capture the high byte and go to RESP.
REQ-025 pmem_ack outside LO_REQ/HI_REQ SHALL be ignored.
REQ-026 A wait counter SHALL clear on entry to each request state; if TIMEOUT cycles elapse in that state without ack, the byte SHALL be treated as complete with read data 8'hFF, and err SHALL set.
REQ-027 mem_resp SHALL be high for exactly the one cycle spent in RESP; RESP SHALL always go to IDLE.
REQ-028 mem_rdata SHALL hold the last assembled word until the next read completes; for writes its value is unchanged.
REQ-029 Latency with same-cycle ack: request accepted at edge N, mem_resp high during cycle N+3 for a two-byte transfer and cycle N+2 for a one-byte write; a be=00 write gives mem_resp during cycle N+1.
REQ-030 CPU request inputs SHALL be sampled only in IDLE; changes in other states SHALL have no effect.

Reset
REQ-031 With rst_n low at an edge: state = IDLE; mem_resp, pmem_req, pmem_we, err = 0; mem_rdata, pmem_address, pmem_wdata = 0; wait counter = 0.
REQ-032 Reset asserted mid-transfer SHALL abandon it: no mem_resp, and pmem_req low from the next cycle.

Verification
REQ-033 Read addr 16'h1235, pmem returns 8'hCD at 16'h1234 and 8'hAB at 16'h1235 with immediate ack -> mem_rdata = 16'hABCD, mem_resp one cycle at N+3.
REQ-034 Write addr 16'h0040, wdata 16'hBEEF, be = 10 -> single pmem write at 16'h0041 with data 8'hBE; no access to 16'h0040.
REQ-035 Write with be = 00 -> mem_resp at N+1; pmem_req never asserted.
REQ-036 Read where pmem_ack is withheld for the high byte (TIMEOUT = 4) -> HI_REQ exits after 4 cycles, mem_rdata[15:8] = 8'hFF, err = 1 and stays 1 until reset.
REQ-037 Read with 3-cycle ack delay per byte -> address, we and wdata stable throughout each request; mem_resp appears exactly once.
REQ-038 rst_n pulsed low while in HI_REQ -> all outputs zero next cycle; a following read completes normally.
